// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encodings for the host command receiver.
// UART_CMD_CHECKSUM_EN adds the CHK parser state (4-byte frames).
package uart_cmd_pkg;

  localparam logic [7:0] HDR_BYTE  = 8'hA5;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_KADC  = 8'h02;
  localparam logic [7:0] CMD_KDAC  = 8'h03;
  localparam logic [7:0] CMD_CH    = 8'h04;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_FRAME   = 3'd1;
  localparam logic [2:0] ERR_UNKNOWN = 3'd2;
  localparam logic [2:0] ERR_BUSY    = 3'd3;
  localparam logic [2:0] ERR_ARG     = 3'd4;
  localparam logic [2:0] ERR_TOUT    = 3'd5;
  localparam logic [2:0] ERR_CHK     = 3'd6;

  typedef enum logic [2:0] {
    P_HDR,
    P_CMD,
    P_ARG,
`ifdef UART_CMD_CHECKSUM_EN
    P_CHK,
`endif
    P_EXEC
  } parse_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_e;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] arg);
    return cmd ^ arg;
  endfunction

  // Clock dividers below 2 would stall the SPI clock generators.
  function automatic logic kdiv_ok(input logic [7:0] arg);
    return arg >= 8'd2;
  endfunction

endpackage

// File: rtl/rs232_rx.sv
// 8N1 byte receiver with 2-flop input synchronizer; rdy/ferr are 1-cycle pulses.
module rs232_rx
  import uart_cmd_pkg::*;
#(
  parameter int Width = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  input  logic [Width-1:0] baud_i,
  output logic             rdy_o,
  output logic             ferr_o,
  output logic [7:0]       data_o
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  rx_state_e        state_q, state_d;
  logic [Width-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             rdy_q, rdy_d;
  logic             ferr_q, ferr_d;

  always_comb begin
    sync1_d = rx_i;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!sync2_q) state_d = RX_START;
      end
      RX_START: begin
        // Half a bit in, so later samples land mid-bit.
        if (cnt_q == (baud_i >> 1)) begin
          cnt_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == baud_i) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == baud_i) begin
          cnt_d = '0;
          if (sync2_q) begin
            rdy_d   = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_WAIT: begin
        // A broken stop bit may be a break; don't re-arm until the line idles.
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rdy_o  = rdy_q;
  assign ferr_o = ferr_q;
  assign data_o = shift_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command frame parser: A5 CMD ARG [CHK] -> start pulse and SPI settings.
// UART_CMD_CHECKSUM_EN enables the trailing CMD^ARG checksum byte.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int         Width      = 15,
  parameter logic [7:0] KmaxAdcRst = 8'd59,
  parameter logic [7:0] KmaxDacRst = 8'd8,
  parameter int         ToutWidth  = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic [Width-1:0]     baud_i,
  input  logic [ToutWidth-1:0] tout_i,
  input  logic                 busy_i,
  output logic                 start_o,
  output logic [7:0]           kmax_adc_o,
  output logic [7:0]           kmax_dac_o,
  output logic [2:0]           ch_o,
  output logic                 err_o,
  output logic [2:0]           errcode_o
);

  logic       rx_rdy;
  logic       rx_ferr;
  logic [7:0] rx_data;

  rs232_rx #(.Width(Width)) u_rx (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .rx_i   (rx_i),
    .baud_i (baud_i),
    .rdy_o  (rx_rdy),
    .ferr_o (rx_ferr),
    .data_o (rx_data)
  );

  parse_state_e         state_q, state_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [7:0]           arg_q, arg_d;
  logic [ToutWidth-1:0] tout_cnt_q, tout_cnt_d;
  logic                 start_q, start_d;
  logic                 err_q, err_d;
  logic [2:0]           errcode_q, errcode_d;
  logic [7:0]           kmax_adc_q, kmax_adc_d;
  logic [7:0]           kmax_dac_q, kmax_dac_d;
  logic [2:0]           ch_q, ch_d;
  logic                 tout_hit;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    start_d    = 1'b0;
    err_d      = 1'b0;
    errcode_d  = errcode_q;
    kmax_adc_d = kmax_adc_q;
    kmax_dac_d = kmax_dac_q;
    ch_d       = ch_q;
    // A received byte always beats a coincident timeout.
    tout_cnt_d = (rx_rdy || state_q == P_HDR) ? '0 : tout_cnt_q + 1'b1;
    tout_hit   = (tout_i != '0) && (tout_cnt_q == tout_i) && !rx_rdy && (state_q != P_HDR);

    case (state_q)
      P_EXEC: begin
        state_d = P_HDR;
        case (cmd_q)
          CMD_START: begin
            if (busy_i) begin
              err_d     = 1'b1;
              errcode_d = ERR_BUSY;
            end else begin
              start_d = 1'b1;
            end
          end
          CMD_KADC, CMD_KDAC: begin
            if (!kdiv_ok(arg_q)) begin
              err_d     = 1'b1;
              errcode_d = ERR_ARG;
            end else if (cmd_q == CMD_KADC) begin
              kmax_adc_d = arg_q;
            end else begin
              kmax_dac_d = arg_q;
            end
          end
          CMD_CH: ch_d = arg_q[2:0];
          default: begin
            err_d     = 1'b1;
            errcode_d = ERR_UNKNOWN;
          end
        endcase
      end
      default: begin
        if (rx_ferr) begin
          err_d     = 1'b1;
          errcode_d = ERR_FRAME;
          state_d   = P_HDR;
        end else if (rx_rdy) begin
          case (state_q)
            P_HDR: if (rx_data == HDR_BYTE) state_d = P_CMD;
            P_CMD: begin
              cmd_d   = rx_data;
              state_d = P_ARG;
            end
            P_ARG: begin
              arg_d = rx_data;
`ifdef UART_CMD_CHECKSUM_EN
              state_d = P_CHK;
`else
              state_d = P_EXEC;
`endif
            end
`ifdef UART_CMD_CHECKSUM_EN
            P_CHK: begin
              if (rx_data == frame_chk(cmd_q, arg_q)) begin
                state_d = P_EXEC;
              end else begin
                err_d     = 1'b1;
                errcode_d = ERR_CHK;
                state_d   = P_HDR;
              end
            end
`endif
            default: state_d = P_HDR;
          endcase
        end else if (tout_hit) begin
          err_d     = 1'b1;
          errcode_d = ERR_TOUT;
          state_d   = P_HDR;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= P_HDR;
      cmd_q      <= '0;
      arg_q      <= '0;
      tout_cnt_q <= '0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      errcode_q  <= ERR_NONE;
      kmax_adc_q <= KmaxAdcRst;
      kmax_dac_q <= KmaxDacRst;
      ch_q       <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      tout_cnt_q <= tout_cnt_d;
      start_q    <= start_d;
      err_q      <= err_d;
      errcode_q  <= errcode_d;
      kmax_adc_q <= kmax_adc_d;
      kmax_dac_q <= kmax_dac_d;
      ch_q       <= ch_d;
    end
  end

  assign start_o    = start_q;
  assign err_o      = err_q;
  assign errcode_o  = errcode_q;
  assign kmax_adc_o = kmax_adc_q;
  assign kmax_dac_o = kmax_dac_q;
  assign ch_o       = ch_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at 16 clocks per bit; checksum cases under UART_CMD_CHECKSUM_EN.
module tb_uart_cmd_rx;

  localparam int BitClks = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [14:0] baud;
  logic [23:0] tout;
  logic        busy;
  logic        start_o;
  logic [7:0]  kmax_adc_o;
  logic [7:0]  kmax_dac_o;
  logic [2:0]  ch_o;
  logic        err_o;
  logic [2:0]  errcode_o;

  int n_cmp = 0;
  int n_mis = 0;
  int start_cnt = 0;
  int err_cnt = 0;

  uart_cmd_rx dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_i       (rx),
    .baud_i     (baud),
    .tout_i     (tout),
    .busy_i     (busy),
    .start_o    (start_o),
    .kmax_adc_o (kmax_adc_o),
    .kmax_dac_o (kmax_dac_o),
    .ch_o       (ch_o),
    .err_o      (err_o),
    .errcode_o  (errcode_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_o) start_cnt <= start_cnt + 1;
    if (err_o)   err_cnt   <= err_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    idle(BitClks);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BitClks);
    end
    rx = stop_bit;
    idle(BitClks);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] arg);
    send_byte(8'hA5, 1'b1);
    send_byte(cmd, 1'b1);
    send_byte(arg, 1'b1);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(cmd ^ arg, 1'b1);
`endif
    idle(20);
  endtask

  int s0, e0, n;

  initial begin
    rst  = 1'b1;
    rx   = 1'b1;
    baud = 15'd15;
    tout = '0;
    busy = 1'b0;
    idle(4);
    check_eq("rst_start", start_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_errcode", errcode_o, 0);
    check_eq("rst_kadc", kmax_adc_o, 59);
    check_eq("rst_kdac", kmax_dac_o, 8);
    check_eq("rst_ch", ch_o, 0);
    rst = 1'b0;
    idle(5);

    // START with sweep idle
    s0 = start_cnt; e0 = err_cnt;
    send_frame(8'h01, 8'h00);
    check_eq("start_pulses", start_cnt - s0, 1);
    check_eq("start_noerr", err_cnt - e0, 0);

    // ADC divider set, then rejected
    e0 = err_cnt;
    send_frame(8'h02, 8'h27);
    check_eq("kadc_set", kmax_adc_o, 39);
    check_eq("kadc_noerr", err_cnt - e0, 0);
    send_frame(8'h02, 8'h01);
    check_eq("kadc_bad_err", err_cnt - e0, 1);
    check_eq("kadc_bad_code", errcode_o, 4);
    check_eq("kadc_kept", kmax_adc_o, 39);

    // DAC divider at the minimum legal value
    send_frame(8'h03, 8'h02);
    check_eq("kdac_min", kmax_dac_o, 2);

    // START while busy
    busy = 1'b1;
    s0 = start_cnt; e0 = err_cnt;
    send_frame(8'h01, 8'h00);
    busy = 1'b0;
    check_eq("busy_nostart", start_cnt - s0, 0);
    check_eq("busy_err", err_cnt - e0, 1);
    check_eq("busy_code", errcode_o, 3);

    // Unknown command
    send_frame(8'h07, 8'h00);
    check_eq("unknown_code", errcode_o, 2);

    // Junk ahead of the header is dropped silently
    e0 = err_cnt;
    send_byte(8'h11, 1'b1);
    send_frame(8'h04, 8'h03);
    check_eq("junk_ch", ch_o, 3);
    check_eq("junk_noerr", err_cnt - e0, 0);

    // Framing error in the CMD slot, then recovery
    e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h55, 1'b0);
    idle(40);
    check_eq("ferr_err", err_cnt - e0, 1);
    check_eq("ferr_code", errcode_o, 1);
    send_frame(8'h04, 8'h05);
    check_eq("ferr_recover_ch", ch_o, 5);

    // Inter-byte timeout
    tout = 24'd2000;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    n = 0;
    while (!err_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("tout_window", (n >= 1990 && n <= 2010), 1);
    check_eq("tout_code", errcode_o, 5);
    idle(5);
    send_frame(8'h04, 8'h06);
    check_eq("tout_recover_ch", ch_o, 6);
    tout = '0;

    // Back-to-back frames without idle gap
    e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h02, 1'b1);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h06, 1'b1);
`endif
    idle(20);
`ifndef UART_CMD_CHECKSUM_EN
    check_eq("b2b_ch", ch_o, 2);
    check_eq("b2b_noerr", err_cnt - e0, 0);
`endif

`ifdef UART_CMD_CHECKSUM_EN
    send_frame(8'h03, 8'h0A);
    check_eq("chk_kdac", kmax_dac_o, 10);
    e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h0C, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(20);
    check_eq("chk_bad_err", err_cnt - e0, 1);
    check_eq("chk_bad_code", errcode_o, 6);
    check_eq("chk_bad_kept", kmax_dac_o, 10);
`endif

    // Reset mid-frame aborts the parser and restores defaults
    s0 = start_cnt; e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(3);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    check_eq("midrst_kadc", kmax_adc_o, 59);
    send_byte(8'h27, 1'b1);
    idle(20);
    check_eq("midrst_kadc_after", kmax_adc_o, 59);
    check_eq("midrst_noerr", err_cnt - e0, 0);
    check_eq("midrst_nostart", start_cnt - s0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Host command receiver for the DAC/ADC/UART sweep chain. Receives 8N1 bytes on the host RX line, parses fixed-length command frames and produces the sweep start pulse and the runtime SPI settings consumed by the sweep top level. Replaces the push-button/single-tick start and the hard-wired ADC/DAC clock dividers and channel selection. The block sits upstream of the sweep FSM, which takes `start_o` as its `start_i`.

## Interface

Parameters:
- `Width`, 15: width of the baud divider.
- `KmaxAdcRst`, 8'd59: reset value of `kmax_adc_o`.
- `KmaxDacRst`, 8'd8: reset value of `kmax_dac_o`.
- `ToutWidth`, 24: width of the inter-byte timeout counter.

Ports:
- `clk_i` in 1: system clock, 100 MHz. One clock; all logic is on its rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `rx_i` in 1: asynchronous host serial line. Idles high.
- `baud_i` in `Width`: clocks per bit minus 1. The value 867 gives 115200 baud.
- `tout_i` in `ToutWidth`: inter-byte timeout in clocks. A value of 0 disables the timeout.
- `busy_i` in 1: high while a sweep is running. Tie it to the inverse of the sweep done indication.
- `start_o` out 1: one-cycle pulse that starts a sweep.
- `kmax_adc_o` out 8: ADC SPI clock divider.
- `kmax_dac_o` out 8: DAC SPI clock divider.
- `ch_o` out 3: ADC channel. The top level inserts it into the ADC command byte.
- `err_o` out 1: one-cycle error pulse.
- `errcode_o` out 3: code of the last error. It is held until the next error.

## Operation

Byte receiver (`rs232_rx`):
- `rx_i` passes through a 2-flop synchronizer.
- States:
  - IDLE: wait for the synchronized line to be 0.
  - START: count (`baud_i`>>1)+1 clocks, then sample. A sample of 1 is a false start; return to IDLE.
  - DATA: 8 samples, each `baud_i`+1 clocks apart, LSB first.
  - STOP: one sample after `baud_i`+1 clocks.
- On stop bit = 1: `rdy` pulses for 1 cycle with the byte.
- On stop bit = 0: `ferr` pulses for 1 cycle. The receiver returns to IDLE only after the line reads 1.

Frame parser FSM: HDR → CMD → ARG → [CHK] → EXEC → HDR.
- HDR accepts only 0xA5. Any other byte is silently dropped and the FSM stays in HDR.
- CMD stores the command byte. ARG stores the argument byte.
- CHK state is present only with `UART_CMD_CHECKSUM_EN`. The byte must equal CMD XOR ARG.
- EXEC lasts 1 cycle:
  - 0x01 START: `start_o` = 1 if `busy_i` = 0. Otherwise error 3. ARG is ignored.
  - 0x02: `kmax_adc_o` ← ARG. ARG < 2 is rejected with error 4 and the register is unchanged.
  - 0x03: `kmax_dac_o` ← ARG. Same ARG < 2 rule as 0x02.
  - 0x04: `ch_o` ← ARG[2:0].
  - Any other command: error 2.
- Error codes: 1 framing, 2 unknown command, 3 busy, 4 bad argument, 5 timeout, 6 checksum.
- Any error returns the FSM to HDR.

Timeout:
- The counter is cleared on every `rdy`.
- It counts while the FSM is not in HDR.
- When it reaches `tout_i` (with `tout_i` ≠ 0): error 5 and the FSM returns to HDR.

## Timing

- Reset values:
  - `start_o` = 0, `err_o` = 0, `errcode_o` = 0.
  - `kmax_adc_o` = `KmaxAdcRst`, `kmax_dac_o` = `KmaxDacRst`, `ch_o` = 0.
  - Both FSMs in IDLE/HDR; all counters 0.
- `rst_i` asserted mid-frame or mid-byte aborts everything. No pulse is produced.
- Latency:
  - `rdy` is asserted 1 cycle after the stop-bit sample.
  - EXEC is entered on the cycle after the final byte's `rdy`.
  - `start_o`, register updates and `err_o` are registered outputs, valid the cycle after EXEC.
- A framing error inside a frame aborts the frame (error 1). In HDR it also reports error 1.
- Timeout and `rdy` in the same cycle: `rdy` wins and the counter is cleared.
- `busy_i` is sampled in EXEC only.
- A START that arrives while `start_o` from the previous frame is still high cannot occur: a frame takes at least 30 bit times.
- Back-to-back frames with no idle gap are supported.

## Configuration

- `UART_CMD_CHECKSUM_EN` defined: 4-byte frames. A CHK mismatch gives error 6 and the command is not executed.
- `UART_CMD_CHECKSUM_EN` undefined: 3-byte frames. The CHK state does not exist and error code 6 is never produced.

## Structure

- Shared package `uart_cmd_pkg` holds:
  - the header constant 0xA5;
  - the command codes 0x01–0x04;
  - the error codes 1–6;
  - the parser state encoding.
- One sub-module: `rs232_rx`, the byte receiver with synchronizer. It is the mirror of the existing `rs232_tx` and is reusable on its own.
- The parser, timeout counter and output registers live in `uart_cmd_rx`.

## Test plan

Run with `baud_i` = 867 and the checksum macro undefined unless stated.
- Frame A5 01 00, `busy_i` = 0 → exactly one `start_o` pulse, about 3 × 10 × 868 clocks after the first start bit. No `err_o`.
- Frame A5 02 27 → `kmax_adc_o` = 39. Then A5 02 01 → `err_o` with code 4 and `kmax_adc_o` remains 39.
- Frame A5 01 00 with `busy_i` = 1 → no `start_o`; `err_o` with `errcode_o` = 3.
- Byte sent with stop bit 0 in the CMD position → `err_o` code 1. A following valid A5 04 05 → `ch_o` = 5.
- `tout_i` = 50000, send A5 04 then stall → `err_o` code 5 at 50000 clocks after the second `rdy`. The next valid frame executes.
- `UART_CMD_CHECKSUM_EN` defined:
  - A5 03 0A 09 → `kmax_dac_o` = 10.
  - A5 03 0A 00 → `err_o` code 6 and `kmax_dac_o` is unchanged.
